// File: rtl/dof_stage_pipe.sv
// ---------------------------------------------------------------------------
// dof_stage_pipe -- decode/operand-fetch pipeline stage.
//
// Takes a decoded instruction and selects its A/B operands. Each operand comes
// from the PC, the immediate, register 0, an EX or WB forward, or the register
// file. The result is registered for the EX stage. A load in EX whose
// destination is a source read from the register file causes a load-use stall.
//
// Handshake: an input instruction is transferred on a cycle where
// in_valid & in_ready. An output instruction is transferred on a cycle where
// out_valid & out_ready. out_* are stable while out_valid & ~out_ready, unless
// flush squashes the held instruction.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   in_valid / in_ready     upstream handshake (in_ready is combinational)
//   in_pc .. in_imm         decoded instruction fields
//   a_data, b_data          register-file read data for in_aa / in_ba
//   ex_*, wb_*              EX/WB destination, write enable and forwarding data
//   flush                   squash: the output register becomes a bubble
//   out_ready / out_valid   downstream handshake
//   out_pc .. out_b         registered stage outputs
//   stall_cnt               saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module dof_stage_pipe #(
  parameter int DW  = 32,
  parameter int PCW = 8,
  parameter int RAW = 5,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PCW-1:0] in_pc,
  input  logic [RAW-1:0] in_aa,
  input  logic [RAW-1:0] in_ba,
  input  logic [RAW-1:0] in_da,
  input  logic           in_rw,
  input  logic           in_mw,
  input  logic           in_ml,
  input  logic           in_ps,
  input  logic           in_ma,
  input  logic           in_mb,
  input  logic [1:0]     in_bs,
  input  logic [4:0]     in_fs,
  input  logic [4:0]     in_sh,
  input  logic [DW-1:0]  in_imm,
  input  logic [DW-1:0]  a_data,
  input  logic [DW-1:0]  b_data,
  input  logic [RAW-1:0] ex_da,
  input  logic [RAW-1:0] wb_da,
  input  logic           ex_rw,
  input  logic           wb_rw,
  input  logic           ex_ml,
  input  logic [DW-1:0]  ex_result,
  input  logic [DW-1:0]  wb_data,
  input  logic           flush,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [PCW-1:0] out_pc,
  output logic [RAW-1:0] out_da,
  output logic           out_rw,
  output logic           out_mw,
  output logic           out_ml,
  output logic [1:0]     out_bs,
  output logic           out_ps,
  output logic [4:0]     out_fs,
  output logic [4:0]     out_sh,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [CW-1:0]  stall_cnt
);

  logic           out_valid_q;
  logic [PCW-1:0] out_pc_q;
  logic [RAW-1:0] out_da_q;
  logic           out_rw_q, out_mw_q, out_ml_q, out_ps_q;
  logic [1:0]     out_bs_q;
  logic [4:0]     out_fs_q, out_sh_q;
  logic [DW-1:0]  out_a_q, out_b_q;
  logic [CW-1:0]  stall_cnt_q;

  logic           advance;
  logic           hazard;
  logic           stall_inc;
  logic [DW-1:0]  opa_d, opb_d;

  // The output register can take a new value when it is empty or being drained.
  assign advance = out_ready | ~out_valid_q;

  // Load-use: the EX load's result is not ready to forward yet, so an
  // instruction reading that register from the file must wait one cycle.
  assign hazard = in_valid & ex_rw & ex_ml & (ex_da != '0) &
                  ((~in_ma & (ex_da == in_aa)) | (~in_mb & (ex_da == in_ba)));

  assign in_ready  = advance & ~hazard;
  assign stall_inc = advance & hazard & ~flush;

  // Operand A. The in_aa == 0 branch also keeps register 0 from ever being
  // forwarded, since any later match would require ex_da/wb_da == 0.
  always_comb begin
    opa_d = a_data;
    if (in_ma) begin
      opa_d = DW'(in_pc);
    end else if (in_aa == '0) begin
      opa_d = '0;
    end else if (ex_rw && !ex_ml && (ex_da == in_aa)) begin
      opa_d = ex_result;
    end else if (wb_rw && (wb_da == in_aa)) begin
      opa_d = wb_data;
    end
  end

  // Operand B, same priority with the immediate in place of the PC.
  always_comb begin
    opb_d = b_data;
    if (in_mb) begin
      opb_d = in_imm;
    end else if (in_ba == '0) begin
      opb_d = '0;
    end else if (ex_rw && !ex_ml && (ex_da == in_ba)) begin
      opb_d = ex_result;
    end else if (wb_rw && (wb_da == in_ba)) begin
      opb_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_da_q    <= '0;
      out_rw_q    <= 1'b0;
      out_mw_q    <= 1'b0;
      out_ml_q    <= 1'b0;
      out_bs_q    <= '0;
      out_ps_q    <= 1'b0;
      out_fs_q    <= '0;
      out_sh_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush || (advance && hazard)) begin
        // Bubble: only the side-effecting controls are cleared; the data
        // fields keep their old contents and are ignored downstream.
        out_valid_q <= 1'b0;
        out_rw_q    <= 1'b0;
        out_mw_q    <= 1'b0;
        out_ml_q    <= 1'b0;
        out_bs_q    <= '0;
      end else if (advance) begin
        // Controls are gated with in_valid so an empty slot never carries
        // a write, load or branch.
        out_valid_q <= in_valid;
        out_rw_q    <= in_rw & in_valid;
        out_mw_q    <= in_mw & in_valid;
        out_ml_q    <= in_ml & in_valid;
        out_bs_q    <= in_bs & {2{in_valid}};
        out_pc_q    <= in_pc;
        out_da_q    <= in_da;
        out_ps_q    <= in_ps;
        out_fs_q    <= in_fs;
        out_sh_q    <= in_sh;
        out_a_q     <= opa_d;
        out_b_q     <= opb_d;
      end
      if (stall_inc && (stall_cnt_q != {CW{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CW'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_da    = out_da_q;
  assign out_rw    = out_rw_q;
  assign out_mw    = out_mw_q;
  assign out_ml    = out_ml_q;
  assign out_bs    = out_bs_q;
  assign out_ps    = out_ps_q;
  assign out_fs    = out_fs_q;
  assign out_sh    = out_sh_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dof_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_dof_stage_pipe -- self-checking bench for dof_stage_pipe (CW = 2 so the
// stall counter saturation is reachable). Directed scenarios followed by a
// randomized run, all checked against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_dof_stage_pipe;

  localparam int DW = 32;
  localparam int PCW = 8;
  localparam int RAW = 5;
  localparam int CW = 2;
  localparam int STALL_MAX = (1 << CW) - 1;
  localparam int VW = 94;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           in_valid, in_ready;
  logic [PCW-1:0] in_pc;
  logic [RAW-1:0] in_aa, in_ba, in_da;
  logic           in_rw, in_mw, in_ml, in_ps, in_ma, in_mb;
  logic [1:0]     in_bs;
  logic [4:0]     in_fs, in_sh;
  logic [DW-1:0]  in_imm, a_data, b_data;
  logic [RAW-1:0] ex_da, wb_da;
  logic           ex_rw, wb_rw, ex_ml;
  logic [DW-1:0]  ex_result, wb_data;
  logic           flush, out_ready, out_valid;
  logic [PCW-1:0] out_pc;
  logic [RAW-1:0] out_da;
  logic           out_rw, out_mw, out_ml, out_ps;
  logic [1:0]     out_bs;
  logic [4:0]     out_fs, out_sh;
  logic [DW-1:0]  out_a, out_b;
  logic [CW-1:0]  stall_cnt;

  dof_stage_pipe #(.DW(DW), .PCW(PCW), .RAW(RAW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_aa(in_aa), .in_ba(in_ba), .in_da(in_da),
    .in_rw(in_rw), .in_mw(in_mw), .in_ml(in_ml), .in_ps(in_ps),
    .in_ma(in_ma), .in_mb(in_mb), .in_bs(in_bs), .in_fs(in_fs),
    .in_sh(in_sh), .in_imm(in_imm), .a_data(a_data), .b_data(b_data),
    .ex_da(ex_da), .wb_da(wb_da), .ex_rw(ex_rw), .wb_rw(wb_rw),
    .ex_ml(ex_ml), .ex_result(ex_result), .wb_data(wb_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_da(out_da), .out_rw(out_rw), .out_mw(out_mw),
    .out_ml(out_ml), .out_bs(out_bs), .out_ps(out_ps), .out_fs(out_fs),
    .out_sh(out_sh), .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state: what the EX stage should currently be seeing.
  logic           m_valid;
  logic [PCW-1:0] m_pc;
  logic [RAW-1:0] m_da;
  logic           m_rw, m_mw, m_ml, m_ps;
  logic [1:0]     m_bs;
  logic [4:0]     m_fs, m_sh;
  logic [DW-1:0]  m_a, m_b;
  int             m_stall;
  logic           exp_ready;
  logic [VW-1:0]  exp_q[$];

  // Value a source register should read: the youngest in-flight producer wins
  // (EX, unless it is a load whose data does not exist yet), then WB, then the
  // register file. Register 0 reads as zero.
  function automatic logic [DW-1:0] src_value(input logic [RAW-1:0] r, input logic [DW-1:0] rf);
    if (r == 0) return '0;
    if (ex_rw && !ex_ml && ex_da == r) return ex_result;
    if (wb_rw && wb_da == r) return wb_data;
    return rf;
  endfunction

  // True when the instruction reads from the file a register an EX load is about to write.
  function automatic logic load_use();
    logic reads_a, reads_b;
    if (!(in_valid && ex_rw && ex_ml) || ex_da == 0) return 1'b0;
    reads_a = !in_ma && in_aa == ex_da;
    reads_b = !in_mb && in_ba == ex_da;
    return reads_a || reads_b;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_valid, m_pc, m_da, m_rw, m_mw, m_ml, m_bs, m_ps, m_fs, m_sh, m_a, m_b};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {out_valid, out_pc, out_da, out_rw, out_mw, out_ml, out_bs, out_ps,
            out_fs, out_sh, out_a, out_b};
  endfunction

  task automatic make_bubble();
    m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_ml = 1'b0; m_bs = 2'b00;
  endtask

  task automatic model_step();
    logic busy, hz;
    busy = m_valid && !out_ready;   // EX still holding our previous output
    hz = load_use();
    exp_ready = !busy && !hz;
    if (reset) begin
      {m_valid, m_pc, m_da, m_rw, m_mw, m_ml, m_bs, m_ps, m_fs, m_sh, m_a, m_b} = '0;
      m_stall = 0;
    end else begin
      if (!busy && hz && !flush) m_stall = (m_stall + 1 > STALL_MAX) ? STALL_MAX : m_stall + 1;
      if (flush) make_bubble();
      else if (busy) ;
      else if (hz) make_bubble();
      else if (!in_valid) make_bubble();
      else begin
        m_valid = 1'b1; m_pc = in_pc; m_da = in_da;
        m_rw = in_rw; m_mw = in_mw; m_ml = in_ml; m_bs = in_bs;
        m_ps = in_ps; m_fs = in_fs; m_sh = in_sh;
        m_a = in_ma ? DW'(in_pc) : src_value(in_aa, a_data);
        m_b = in_mb ? in_imm     : src_value(in_ba, b_data);
      end
    end
    exp_q.push_back(model_vec());
  endtask

  // One clock: inputs already driven (at negedge). Returns at the next negedge.
  task automatic tick();
    logic [VW-1:0] e, g;
    #1;
    model_step();
    check_eq("in_ready", 128'(in_ready), 128'(exp_ready));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    g = dut_vec();
    if (e[93]) check_eq("out_all", 128'(g), 128'(e));
    else       check_eq("out_ctrl", 128'({g[93], g[79:75]}), 128'({e[93], e[79:75]}));
    check_eq("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_aa = '0; in_ba = '0; in_da = '0;
    in_rw = 1'b0; in_mw = 1'b0; in_ml = 1'b0; in_ps = 1'b0;
    in_ma = 1'b0; in_mb = 1'b0; in_bs = '0; in_fs = '0; in_sh = '0;
    in_imm = '0; a_data = '0; b_data = '0;
    ex_da = '0; wb_da = '0; ex_rw = 1'b0; wb_rw = 1'b0; ex_ml = 1'b0;
    ex_result = '0; wb_data = '0;
  endtask

  task automatic drive_random();
    reset = ($urandom_range(0, 63) == 0);
    flush = ($urandom_range(0, 7) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    in_valid = ($urandom_range(0, 4) != 0);
    in_pc = PCW'($urandom); in_da = RAW'($urandom_range(0, 31));
    in_aa = RAW'($urandom_range(0, 3)); in_ba = RAW'($urandom_range(0, 3));
    {in_rw, in_mw, in_ml, in_ps} = 4'($urandom);
    in_ma = ($urandom_range(0, 3) == 0); in_mb = ($urandom_range(0, 3) == 0);
    in_bs = 2'($urandom); in_fs = 5'($urandom); in_sh = 5'($urandom);
    in_imm = $urandom; a_data = $urandom; b_data = $urandom;
    ex_da = RAW'($urandom_range(0, 3)); wb_da = RAW'($urandom_range(0, 3));
    ex_rw = $urandom_range(0, 1); wb_rw = $urandom_range(0, 1);
    ex_ml = ($urandom_range(0, 2) == 0);
    ex_result = $urandom; wb_data = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    {m_valid, m_pc, m_da, m_rw, m_mw, m_ml, m_bs, m_ps, m_fs, m_sh, m_a, m_b} = '0;
    m_stall = 0;
    check_eq("reset_out", 128'(dut_vec()), 128'(0));
    check_eq("reset_stall", 128'(stall_cnt), 128'(0));
    reset = 1'b0;

    // ADD r3 = r1 + r2
    in_valid = 1; in_aa = 1; in_ba = 2; in_da = 3; in_rw = 1; in_fs = 5'd2;
    a_data = 5; b_data = 7; in_pc = 8'h10;
    tick();
    check_eq("add_valid", 128'(out_valid), 128'(1));
    check_eq("add_a", 128'(out_a), 128'(5));
    check_eq("add_b", 128'(out_b), 128'(7));
    check_eq("add_da", 128'(out_da), 128'(3));

    // EX beats WB on the same register
    set_idle();
    in_valid = 1; in_aa = 4; ex_rw = 1; ex_da = 4; ex_result = 32'h11;
    wb_rw = 1; wb_da = 4; wb_data = 32'h22; a_data = 32'h99;
    tick();
    check_eq("fwd_ex_prio", 128'(out_a), 128'(32'h11));
    ex_rw = 0;
    tick();
    check_eq("fwd_wb", 128'(out_a), 128'(32'h22));
    // register 0 is never forwarded
    in_aa = 0; ex_rw = 1; ex_da = 0; wb_da = 0;
    tick();
    check_eq("fwd_r0", 128'(out_a), 128'(0));
    // A-mux selects PC, B-mux selects immediate
    in_ma = 1; in_mb = 1; in_pc = 8'hA5; in_imm = 32'hDEAD_BEEF;
    tick();
    check_eq("mux_pc", 128'(out_a), 128'(32'hA5));
    check_eq("mux_imm", 128'(out_b), 128'(32'hDEAD_BEEF));

    // Load-use stall then acceptance with WB forward
    set_idle();
    do_reset();
    in_valid = 1; in_ba = 2; in_mb = 0; in_da = 6; in_rw = 1;
    ex_rw = 1; ex_ml = 1; ex_da = 2; b_data = 32'h77;
    #1 check_eq("lu_ready", 128'(in_ready), 128'(0));
    tick();
    check_eq("lu_bubble", 128'(out_valid), 128'(0));
    check_eq("lu_stall1", 128'(stall_cnt), 128'(1));
    ex_rw = 0; ex_ml = 0; wb_rw = 1; wb_da = 2; wb_data = 9;
    tick();
    check_eq("lu_accept", 128'(out_valid), 128'(1));
    check_eq("lu_b", 128'(out_b), 128'(9));

    // Backpressure: outputs hold for 3 cycles
    set_idle();
    in_valid = 1; in_pc = 8'h40; in_da = 7; in_rw = 1;
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_pc = 8'h50 + 8'(i);
      tick();
      check_eq("bp_hold_pc", 128'(out_pc), 128'(8'h40));
      check_eq("bp_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1; in_pc = 8'h60;
    tick();
    check_eq("bp_release", 128'(out_pc), 128'(8'h60));

    // Flush squashes a held store
    set_idle();
    in_valid = 1; in_mw = 1; in_pc = 8'h70;
    tick();
    out_ready = 0;
    tick();
    flush = 1;
    tick();
    check_eq("flush_valid", 128'(out_valid), 128'(0));
    check_eq("flush_mw", 128'(out_mw), 128'(0));
    // Flush while the input is accepted: instruction discarded
    out_ready = 1; in_pc = 8'h71;
    tick();
    check_eq("flush_discard", 128'(out_valid), 128'(0));

    // Stall counter saturation then reset
    set_idle();
    do_reset();
    in_valid = 1; in_aa = 3; ex_rw = 1; ex_ml = 1; ex_da = 3;
    for (int i = 0; i < 5; i++) tick();
    check_eq("stall_sat", 128'(stall_cnt), 128'(3));
    // reset mid-stall
    reset = 1;
    tick();
    check_eq("stall_reset", 128'(stall_cnt), 128'(0));
    check_eq("reset_valid", 128'(out_valid), 128'(0));
    reset = 0;

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/dof_stage_pipe.md
DOF_STAGE_PIPE -- requirements
Module: dof_stage_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - DW, 32, datapath width.
  - PCW, 8, PC width.
  - RAW, 5, register address width.
  - CW, 16, stall counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk  in  1  clock; all state updates on rising edge.
  - reset  in  1  reset, synchronous, active-high.
  - in_valid  in  1  decoded instruction present.
  - in_ready  out  1  instruction accepted this cycle.
  - in_pc  in  PCW  PC+1 of instruction.
  - in_aa, in_ba, in_da  in  RAW each  source A/B, destination register.
  - in_rw, in_mw, in_ml, in_ps, in_ma, in_mb  in  1 each  reg write, mem write, load, polarity, A-mux (1=PC), B-mux (1=imm).
  - in_bs  in  2  branch select.
  - in_fs  in  5  function select.
  - in_sh  in  5  shift amount.
  - in_imm  in  DW  extended immediate.
  - a_data, b_data  in  DW  register-file read ports.
  - ex_da, wb_da  in  RAW  EX/WB destination.
  - ex_rw, wb_rw, ex_ml  in  1  EX/WB write enable, EX is load.
  - ex_result, wb_data  in  DW  forwarding values.
  - flush  in  1  branch mispredict squash.
  - out_ready  in  1  EX stage accepts.
  - out_valid  out  1  output register valid.
  - out_pc, out_da, out_rw, out_mw, out_ml, out_bs, out_ps, out_fs, out_sh, out_a, out_b  out  matching widths  registered stage outputs.
  - stall_cnt  out  CW  load-use stall cycles.

Function
REQ-003 advance = out_ready | ~out_valid; output register loads only when advance=1, otherwise holds all out_* values.
REQ-004 hazard = in_valid & ex_rw & ex_ml & (ex_da!=0) & ((~in_ma & ex_da==in_aa) | (~in_mb & ex_da==in_ba)).
REQ-005 in_ready = advance & ~hazard (combinational).
REQ-006 Operand A: in_ma=1 -> in_pc zero-extended to DW; else in_aa==0 -> 0; else EX match (ex_rw, ex_da==in_aa, ~ex_ml) -> ex_result; else WB match (wb_rw, wb_da==in_aa) -> wb_data; else a_data.
REQ-007 Operand B: same rules as A using in_mb, in_ba, b_data; in_mb=1 -> in_imm.
REQ-008 EX forwarding has priority over WB when both match the same register.
REQ-009 On advance & ~hazard & ~flush: out_valid<=in_valid; all out_* fields <= inputs and forwarded operands.
REQ-010 On advance & hazard & ~flush: bubble loaded; the instruction stays at input.
REQ-011 Bubble: out_valid=0, out_rw=0, out_mw=0, out_ml=0, out_bs=0; other fields don't-care.
REQ-012 Whenever out_valid=0, out_rw, out_mw, out_ml and out_bs SHALL be 0.
REQ-013 flush=1 loads a bubble regardless of advance or hazard; if in_ready=1 that cycle, the accepted input is discarded.
REQ-014 Latency: one cycle from acceptance to out_valid.
REQ-015 stall_cnt increments by 1 on each cycle with hazard & advance & ~flush.
REQ-016 stall_cnt saturates at 2^CW-1 without wrap-around.
REQ-017 Register 0 never forwards, even if ex_da/wb_da==0 with write enable set.

Reset
REQ-018 reset=1 at a rising edge clears every out_* field, out_valid and stall_cnt to 0.
REQ-019 Reset has priority over flush, hazard and advance.
REQ-020 Reset asserted mid-stall discards the held instruction state; in_ready follows REQ-005 combinationally.

Verification
REQ-021 Scenarios:
  - ADD r3=r1+r2, a_data=5, b_data=7, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_da=3.
  - in_aa=4, ex_rw=1, ex_da=4, ex_result=0x11; wb_rw=1, wb_da=4, wb_data=0x22 -> out_a=0x11.
  - Load-use: ex_ml=1, ex_da=2, in_ba=2, in_mb=0 -> in_ready=0, bubble, stall_cnt=1. Next cycle ex_rw=0, wb_da=2, wb_data=9 -> accepted, out_b=9.
  - out_ready=0 with out_valid=1 for 3 cycles -> outputs constant, in_ready=0. Release -> new instruction loaded.
  - flush=1 with out_ready=0 and valid store held -> next cycle out_valid=0, out_mw=0.
  - CW=2, 5 consecutive hazard cycles -> stall_cnt=3. reset -> stall_cnt=0.
